bit_serial_alu: RTL and testbench



---
 rtl/bit_serial_alu_if.sv | 27 ++
 rtl/bit_serial_alu.sv | 139 +++++++++++++
 tb/tb_bit_serial_alu.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bit_serial_alu_if.sv
// Request/response bundle for bit_serial_alu: a valid/ready start port with
// the operands, and a valid/ready result port with the flags.
interface bit_serial_alu_if #(
    parameter int WIDTH = 32
);
    logic             start_valid;
    logic             start_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             zero;
    logic             overflow;

    modport master (
        output start_valid, op, a, b, res_ready,
        input  start_ready, res_valid, result, carryout, zero, overflow
    );

    modport slave (
        input  start_valid, op, a, b, res_ready,
        output start_ready, res_valid, result, carryout, zero, overflow
    );
endinterface

// File: rtl/bit_serial_alu.sv
// Bit-serial WIDTH-bit ALU: one operand bit per clock through a 1-bit slice,
// LSB first. Define BIT_SERIAL_FLAGS_EN to drive the zero/overflow flags.
module bit_serial_alu #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    bit_serial_alu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000, OP_SUB = 3'b001, OP_XOR = 3'b010, OP_SLT = 3'b011,
        OP_AND  = 3'b100, OP_NAND = 3'b101, OP_NOR = 3'b110, OP_OR  = 3'b111
    } op_e;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e           state_q, state_d;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, carryout_q;

    logic arith, invert_b, b_eff, sum, cout, slice_bit, last_step, ovf_bit, slt_bit;

    // The single 1-bit slice, fed from the low end of the operand shifters.
    assign arith     = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
    assign invert_b  = (op_q == OP_SUB) || (op_q == OP_SLT);
    assign b_eff     = b_q[0] ^ invert_b;
    assign sum       = a_q[0] ^ b_eff ^ carry_q;
    assign cout      = (a_q[0] & b_eff) | (carry_q & (a_q[0] ^ b_eff));
    assign last_step = (cnt_q == CW'(WIDTH - 1));
    // On the MSB step carry_q still holds the carry into the MSB.
    assign ovf_bit   = carry_q ^ cout;
    assign slt_bit   = sum ^ ovf_bit;

    always_comb begin
        // NOTE: default first so no path through the case leaves slice_bit unassigned (no latch).
        slice_bit = sum;
        unique case (op_q)
            OP_XOR:  slice_bit = a_q[0] ^ b_q[0];
            OP_AND:  slice_bit = a_q[0] & b_q[0];
            OP_NAND: slice_bit = ~(a_q[0] & b_q[0]);
            OP_NOR:  slice_bit = ~(a_q[0] | b_q[0]);
            OP_OR:   slice_bit = a_q[0] | b_q[0];
            default: slice_bit = sum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.start_ready = 1'b0;
        bus.res_valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.start_ready = 1'b1;
                if (bus.start_valid) state_d = SHIFT;
            end
            SHIFT: if (last_step) state_d = DONE;
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef BIT_SERIAL_FLAGS_EN
    logic any_one_q, zero_q, overflow_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: operand/result shifters are plain flops, so they take the async reset too.
        if (!rst_n) begin
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            carryout_q <= 1'b0;
`ifdef BIT_SERIAL_FLAGS_EN
            any_one_q  <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: if (bus.start_valid) begin
                    a_q        <= bus.a;
                    b_q        <= bus.b;
                    op_q       <= op_e'(bus.op);
                    cnt_q      <= '0;
                    carry_q    <= (bus.op == OP_SUB) || (bus.op == OP_SLT);
                    carryout_q <= 1'b0;
`ifdef BIT_SERIAL_FLAGS_EN
                    any_one_q  <= 1'b0;
                    zero_q     <= 1'b0;
                    overflow_q <= 1'b0;
`endif
                end
                SHIFT: begin
                    a_q   <= {1'b0, a_q[WIDTH-1:1]};
                    b_q   <= {1'b0, b_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + CW'(1);
                    if (arith) carry_q <= cout;
                    if (last_step && op_q == OP_SLT) res_q <= {{(WIDTH-1){1'b0}}, slt_bit};
                    else                             res_q <= {slice_bit, res_q[WIDTH-1:1]};
                    if (last_step) carryout_q <= arith ? cout : 1'b0;
`ifdef BIT_SERIAL_FLAGS_EN
                    any_one_q <= any_one_q | slice_bit;
                    if (last_step) begin
                        zero_q     <= (op_q == OP_SLT) ? ~slt_bit : ~(any_one_q | slice_bit);
                        overflow_q <= arith ? ovf_bit : 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.result   = res_q;
    assign bus.carryout = carryout_q;
`ifdef BIT_SERIAL_FLAGS_EN
    assign bus.zero     = zero_q;
    assign bus.overflow = overflow_q;
`else
    assign bus.zero     = 1'b0;
    assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_bit_serial_alu.sv
// Self-checking bench for bit_serial_alu (WIDTH=32): vector table plus
// hand-written backpressure and mid-operation reset sequences.
module tb_bit_serial_alu;
    localparam int W = 32;
`ifdef BIT_SERIAL_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    bit_serial_alu_if #(.WIDTH(W)) bus ();
    bit_serial_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [W-1:0] a, b, res;
        logic       c, z, v;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one operation and waits for res_valid. lat counts clock edges
    // with the acceptance edge as 1, so a WIDTH-bit op gives WIDTH+1.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
        int guard = 0;
        @(negedge clk);
        bus.op = op; bus.a = a; bus.b = b; bus.start_valid = 1'b1; bus.res_ready = 1'b0;
        while (!bus.start_ready && guard < 100) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        lat = 1;
        while (!bus.res_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        if (!bus.res_valid) check("res_valid_timeout", 32'(bus.res_valid), 32'd1);
    endtask

    task automatic release_result();
        @(negedge clk); bus.res_ready = 1'b1;
        @(posedge clk); #1; bus.res_ready = 1'b0;
    endtask

    initial begin
        int lat;
        localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, XOR_ = 3'b010, SLT = 3'b011,
                               AND_ = 3'b100, NAND_ = 3'b101, NOR_ = 3'b110, OR_ = 3'b111;

        vecs.push_back('{"add_wrap",   ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0});
        vecs.push_back('{"sub_ovf",    SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 0, 1});
        vecs.push_back('{"slt_neg",    SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1, 0, 0});
        vecs.push_back('{"slt_ovfcor", SLT,   32'h7FFFFFFF, 32'h80000000, 32'h00000000, 0, 1, 1});
        vecs.push_back('{"xor",        XOR_,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0});
        vecs.push_back('{"and",        AND_,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0});
        vecs.push_back('{"nand",       NAND_, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 0, 0, 0});
        vecs.push_back('{"nor",        NOR_,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 0, 0, 0});
        vecs.push_back('{"or",         OR_,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0});
        vecs.push_back('{"add_ovf",    ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1});
        vecs.push_back('{"sub_eq",     SUB,   32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0});
        vecs.push_back('{"sub_borrow", SUB,   32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 0});
        vecs.push_back('{"and_zero",   AND_,  32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 0, 1, 0});

        bus.start_valid = 1'b0; bus.res_ready = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start_ready", 32'(bus.start_ready), 32'd1);
        check("rst_res_valid",   32'(bus.res_valid),   32'd0);
        check("rst_result",      bus.result,           32'd0);
        check("rst_flags", {29'd0, bus.carryout, bus.zero, bus.overflow}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check({vecs[i].name, "_latency"},  32'(lat),             32'd33);
            check({vecs[i].name, "_result"},   bus.result,           vecs[i].res);
            check({vecs[i].name, "_carryout"}, 32'(bus.carryout),    32'(vecs[i].c));
            check({vecs[i].name, "_zero"},     32'(bus.zero),        32'(FLAGS_EN & vecs[i].z));
            check({vecs[i].name, "_overflow"}, 32'(bus.overflow),    32'(FLAGS_EN & vecs[i].v));
            release_result();
            check({vecs[i].name, "_to_idle"}, {30'd0, bus.start_ready, bus.res_valid}, 32'd2);
        end

        // Backpressure: DONE must hold and ignore a pending new request.
        issue(ADD, 32'd1, 32'd2, lat);
        @(negedge clk);
        bus.start_valid = 1'b1; bus.op = SUB; bus.a = 32'hDEADBEEF; bus.b = 32'h12345678;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_result", bus.result, 32'd3);
            check("bp_ready_valid", {30'd0, bus.start_ready, bus.res_valid}, 32'd1);
        end
        @(negedge clk); bus.start_valid = 1'b0; bus.res_ready = 1'b1;
        @(posedge clk); #1; bus.res_ready = 1'b0;
        check("bp_idle", {30'd0, bus.start_ready, bus.res_valid}, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_capture", bus.result, 32'd3);

        // Reset asserted after 10 shift steps of an ADD.
        @(negedge clk);
        bus.op = ADD; bus.a = 32'h12345678; bus.b = 32'h11111111; bus.start_valid = 1'b1;
        @(posedge clk); #1; bus.start_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_partial_nonzero", 32'(bus.result != 0), 32'd1);
        rst_n = 1'b0; #1;
        check("mid_rst_result", bus.result, 32'd0);
        check("mid_rst_flags", {29'd0, bus.carryout, bus.zero, bus.overflow}, 32'd0);
        check("mid_rst_hs", {30'd0, bus.start_ready, bus.res_valid}, 32'd2);
        @(negedge clk); rst_n = 1'b1;
        #1;
        check("mid_rel_ready", 32'(bus.start_ready), 32'd1);
        issue(ADD, 32'd3, 32'd4, lat);
        check("post_rst_latency", 32'(lat), 32'd33);
        check("post_rst_result", bus.result, 32'd7);
        release_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
